// File: rtl/vqueue_fill_pkg.sv
// Shared definitions for the video queue write-side fill engine:
// FSM encoding, queue refill threshold and default framebuffer geometry.
package vqueue_fill_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_DATA = 2'd2
   } fill_state_t;

   // Queue reports AlmostEmpty below this many words
   localparam int AE_THRESHOLD  = 32;
   // 1024x768 at 1 bpp packed into 32-bit words
   localparam int DEF_FB_WORDS  = 24576;
   // Words per memory read burst
   localparam int DEF_BURST_LEN = 8;

endpackage

// File: rtl/vqueue_fill.sv
// Write-side engine of the video queue. Fetches framebuffer words in fixed
// bursts whenever the queue runs low, walks the frame linearly, wraps at end
// of frame and re-syncs to the base address on a frame-start pulse.
module vqueue_fill
   import vqueue_fill_pkg::*;
#(
   parameter int                    addr_width = 24,
   parameter logic [addr_width-1:0] fb_base    = {addr_width{1'b0}},
   parameter int                    fb_words   = DEF_FB_WORDS,
   parameter int                    burst_len  = DEF_BURST_LEN
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  enable,
   input  logic                  frame_start,
   input  logic                  q_almost_empty,
   output logic                  q_wren,
   output logic [31:0]           q_data,
   output logic                  mem_req,
   output logic [addr_width-1:0] mem_addr,
   input  logic                  mem_ack,
   input  logic                  mem_rvalid,
   input  logic [31:0]           mem_rdata,
   output logic                  busy
);

   localparam int                    BEAT_W      = $clog2(burst_len);
   localparam logic [addr_width-1:0] BURST_INC   = addr_width'(burst_len);
   localparam logic [addr_width-1:0] FRAME_WORDS = addr_width'(fb_words);
   localparam logic [BEAT_W-1:0]     LAST_BEAT   = BEAT_W'(burst_len - 1);
   localparam logic [BEAT_W-1:0]     BEAT_ONE    = BEAT_W'(1'b1);

   fill_state_t           state_r;
   fill_state_t           state_s;
   logic [addr_width-1:0] fetch_addr_r;
   logic [addr_width-1:0] word_cnt_r;
   logic [BEAT_W-1:0]     beat_cnt_r;
   logic                  restart_pend_r;
   logic                  mem_req_r;
   logic                  busy_r;
   logic                  q_wren_r;
   logic [31:0]           q_data_r;

   logic                  restart_s;
   logic                  beat_s;
   logic                  last_beat_s;
   logic [addr_width-1:0] addr_sum_s;
   logic [addr_width-1:0] word_sum_s;

   // Next-state decode; a frame start seen in IDLE restarts immediately so
   // no request is ever launched from a stale address.
   always_comb begin
      state_s     = state_r;
      restart_s   = 1'b0;
      beat_s      = 1'b0;
      last_beat_s = 1'b0;
      addr_sum_s  = fetch_addr_r + BURST_INC;
      word_sum_s  = word_cnt_r + BURST_INC;
      case (state_r)
         ST_IDLE: begin
            if (restart_pend_r || frame_start) begin
               restart_s = 1'b1;
               state_s   = ST_IDLE;
            end else if (enable && q_almost_empty) begin
               state_s = ST_REQ;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_REQ: begin
            if (mem_ack) begin
               state_s = ST_DATA;
            end else begin
               state_s = ST_REQ;
            end
         end
         ST_DATA: begin
            if (mem_rvalid) begin
               beat_s = 1'b1;
               if (beat_cnt_r == LAST_BEAT) begin
                  last_beat_s = 1'b1;
                  state_s     = ST_IDLE;
               end else begin
                  state_s = ST_DATA;
               end
            end else begin
               state_s = ST_DATA;
            end
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase
   end

   // FSM state register and registered handshake/status outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r   <= ST_IDLE;
         mem_req_r <= 1'b0;
         busy_r    <= 1'b0;
      end else begin
         state_r   <= state_s;
         mem_req_r <= (state_s == ST_REQ);
         busy_r    <= (state_s != ST_IDLE);
      end
   end

   // Restart flag: armed by frame_start in any state, consumed in IDLE
   always_ff @(posedge clk) begin
      if (reset) begin
         restart_pend_r <= 1'b0;
      end else if (restart_s) begin
         restart_pend_r <= 1'b0;
      end else if (frame_start) begin
         restart_pend_r <= 1'b1;
      end else begin
         restart_pend_r <= restart_pend_r;
      end
   end

   // Fetch address and frame word counter, advanced once per completed burst
   always_ff @(posedge clk) begin
      if (reset || restart_s) begin
         fetch_addr_r <= fb_base;
         word_cnt_r   <= {addr_width{1'b0}};
      end else if (last_beat_s) begin
         if (word_sum_s == FRAME_WORDS) begin
            fetch_addr_r <= fb_base;
            word_cnt_r   <= {addr_width{1'b0}};
         end else begin
            fetch_addr_r <= addr_sum_s;
            word_cnt_r   <= word_sum_s;
         end
      end else begin
         fetch_addr_r <= fetch_addr_r;
         word_cnt_r   <= word_cnt_r;
      end
   end

   // Beat counter: cleared while requesting, counts accepted beats in DATA
   always_ff @(posedge clk) begin
      if (reset || (state_r == ST_REQ)) begin
         beat_cnt_r <= {BEAT_W{1'b0}};
      end else if (beat_s) begin
         beat_cnt_r <= beat_cnt_r + BEAT_ONE;
      end else begin
         beat_cnt_r <= beat_cnt_r;
      end
   end

   // Queue write path: one registered stage from accepted beat to WrEn/Data
   always_ff @(posedge clk) begin
      if (reset) begin
         q_wren_r <= 1'b0;
         q_data_r <= 32'h0;
      end else if (beat_s) begin
         q_wren_r <= 1'b1;
         q_data_r <= mem_rdata;
      end else begin
         q_wren_r <= 1'b0;
         q_data_r <= q_data_r;
      end
   end

   assign mem_req  = mem_req_r;
   assign mem_addr = fetch_addr_r;
   assign busy     = busy_r;
   assign q_wren   = q_wren_r;
   assign q_data   = q_data_r;

endmodule

// File: tb/tb_vqueue_fill.sv
// Self-checking bench for vqueue_fill: directed burst table, hand-written
// throttle/reset sequences and a randomized run against a transaction model.
module tb_vqueue_fill;

   localparam int          AW      = 24;
   localparam logic [23:0] FB_BASE = 24'h100;
   localparam int          FBW     = 32;
   localparam int          BL      = 8;

   logic        clk;
   logic        reset;
   logic        enable;
   logic        frame_start;
   logic        q_almost_empty;
   logic        q_wren;
   logic [31:0] q_data;
   logic        mem_req;
   logic [23:0] mem_addr;
   logic        mem_ack;
   logic        mem_rvalid;
   logic [31:0] mem_rdata;
   logic        busy;

   vqueue_fill #(
      .addr_width (AW),
      .fb_base    (FB_BASE),
      .fb_words   (FBW),
      .burst_len  (BL)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .enable         (enable),
      .frame_start    (frame_start),
      .q_almost_empty (q_almost_empty),
      .q_wren         (q_wren),
      .q_data         (q_data),
      .mem_req        (mem_req),
      .mem_addr       (mem_addr),
      .mem_ack        (mem_ack),
      .mem_rvalid     (mem_rvalid),
      .mem_rdata      (mem_rdata),
      .busy           (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp  = 0;
   int n_fail = 0;

   // Transaction-level model: word offset into the frame, pending restart,
   // and beats still owed by the burst the memory has accepted.
   int m_off  = 0;
   bit m_pend = 1'b0;
   int m_left = 0;

   typedef struct {
      int          ack_dly;
      int          gap;
      int          fs_beat;
      int          exp_wait;
      logic [23:0] exp_addr;
   } vec_t;

   vec_t tbl [8];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // One clock: predict from the inputs about to be sampled, then check
   // the outputs #1 after the edge.
   task automatic step();
      bit          acc;
      bit          ack_now;
      bit          fs;
      logic [31:0] d;
      logic        prev_req;
      logic [23:0] prev_addr;
      acc       = mem_rvalid && (m_left > 0) && !reset;
      ack_now   = mem_ack && mem_req && !reset;
      fs        = frame_start && !reset;
      d         = mem_rdata;
      prev_req  = mem_req;
      prev_addr = mem_addr;
      @(posedge clk);
      #1;
      if (reset) begin
         m_off  = 0;
         m_pend = 1'b0;
         m_left = 0;
      end else begin
         if (fs) m_pend = 1'b1;
         if (acc) begin
            m_left--;
            if (m_left == 0) m_off = (m_off + BL) % FBW;
         end
         if (ack_now) m_left = BL;
      end
      check("q_wren", 32'(q_wren), 32'(acc));
      if (acc) check("q_data", q_data, d);
      if (mem_req && !prev_req) begin
         if (m_pend) begin
            m_off  = 0;
            m_pend = 1'b0;
         end
         check("req_addr", 32'(mem_addr), 32'(FB_BASE) + 32'(m_off));
      end
      if (mem_req && prev_req) check("addr_stable", 32'(mem_addr), 32'(prev_addr));
      if (ack_now) check("req_drop", 32'(mem_req), 32'd0);
   endtask

   task automatic run_burst(input int ack_dly, input int gap, input int fs_beat,
                            input int ae_low_beat, input int exp_wait,
                            input logic [23:0] exp_addr, input int tag);
      int w;
      w = 0;
      while (!mem_req && (w < 50)) begin
         step();
         w++;
      end
      if (!mem_req) begin
         check("req_timeout", 32'(mem_req), 32'd1);
         return;
      end
      if (exp_wait >= 0) check("idle_gap", 32'(w), 32'(exp_wait));
      check("burst_addr", 32'(mem_addr), 32'(exp_addr));
      check("busy_req", 32'(busy), 32'd1);
      for (int i = 0; i < ack_dly; i++) begin
         step();
         check("req_hold", 32'(mem_req), 32'd1);
      end
      mem_ack = 1'b1;
      step();
      mem_ack = 1'b0;
      for (int b = 0; b < BL; b++) begin
         for (int g = 0; g < gap; g++) step();
         mem_rvalid  = 1'b1;
         mem_rdata   = 32'(tag * BL + b);
         frame_start = (b == fs_beat);
         if (b == ae_low_beat) q_almost_empty = 1'b0;
         step();
         mem_rvalid  = 1'b0;
         frame_start = 1'b0;
         check("busy_data", 32'(busy), (b == BL - 1) ? 32'd0 : 32'd1);
      end
   endtask

   initial begin
      reset          = 1'b1;
      enable         = 1'b0;
      frame_start    = 1'b0;
      q_almost_empty = 1'b0;
      mem_ack        = 1'b0;
      mem_rvalid     = 1'b0;
      mem_rdata      = 32'h0;

      // Directed burst table (base 0x100, 32-word frame, 8-word bursts)
      tbl[0] = '{2,  0, -1, 1, 24'h100};
      tbl[1] = '{10, 1, -1, 1, 24'h108};
      tbl[2] = '{0,  0,  3, 1, 24'h110};
      tbl[3] = '{1,  2, -1, 2, 24'h100};
      tbl[4] = '{0,  0, -1, 1, 24'h108};
      tbl[5] = '{3,  1, -1, 1, 24'h110};
      tbl[6] = '{0,  0, -1, 1, 24'h118};
      tbl[7] = '{1,  0, -1, 1, 24'h100};

      step();
      step();
      check("rst_mem_req", 32'(mem_req), 32'd0);
      check("rst_q_wren",  32'(q_wren),  32'd0);
      check("rst_q_data",  q_data,       32'd0);
      check("rst_busy",    32'(busy),    32'd0);
      check("rst_addr",    32'(mem_addr), 32'(FB_BASE));

      reset          = 1'b0;
      enable         = 1'b1;
      q_almost_empty = 1'b1;
      for (int i = 0; i < 8; i++) begin
         run_burst(tbl[i].ack_dly, tbl[i].gap, tbl[i].fs_beat, -1,
                   tbl[i].exp_wait, tbl[i].exp_addr, i);
      end

      // Throttle: AlmostEmpty drops mid-burst, burst still completes
      run_burst(0, 0, -1, 2, 1, 24'h108, 8);
      for (int i = 0; i < 10; i++) begin
         step();
         check("throttle_noreq", 32'(mem_req), 32'd0);
      end
      q_almost_empty = 1'b1;
      step();
      check("throttle_resume", 32'(mem_req), 32'd1);
      run_burst(0, 0, -1, -1, 0, 24'h110, 9);

      // Reset mid-burst, with a coincident frame_start that must be dropped
      run_burst(0, 0, -1, -1, 1, 24'h118, 10);
      while (!mem_req) step();
      mem_ack = 1'b1;
      step();
      mem_ack = 1'b0;
      for (int b = 0; b < 3; b++) begin
         mem_rvalid = 1'b1;
         mem_rdata  = 32'hA000 + 32'(b);
         step();
      end
      reset       = 1'b1;
      frame_start = 1'b1;
      step();
      reset       = 1'b0;
      frame_start = 1'b0;
      check("mrst_mem_req", 32'(mem_req), 32'd0);
      check("mrst_q_wren",  32'(q_wren),  32'd0);
      check("mrst_q_data",  q_data,       32'd0);
      check("mrst_busy",    32'(busy),    32'd0);
      for (int i = 0; i < 5; i++) begin
         mem_rvalid = 1'b1;
         mem_rdata  = 32'hB000 + 32'(i);
         step();
         check("stray_wren", 32'(q_wren), 32'd0);
         if (i == 0) check("post_rst_req", 32'(mem_req), 32'd1);
      end
      mem_rvalid = 1'b0;
      run_burst(0, 0, -1, -1, 0, FB_BASE, 11);

      // Randomized traffic against the model
      for (int c = 0; c < 4000; c++) begin
         if ($urandom_range(0, 9) == 0) q_almost_empty = ~q_almost_empty;
         if ($urandom_range(0, 14) == 0) enable = ~enable;
         frame_start = ($urandom_range(0, 29) == 0);
         reset       = ($urandom_range(0, 399) == 0);
         mem_ack     = mem_req && ($urandom_range(0, 2) == 0);
         if (m_left > 0) mem_rvalid = ($urandom_range(0, 3) != 0);
         else            mem_rvalid = ($urandom_range(0, 9) == 0);
         mem_rdata = $urandom;
         step();
      end

      reset       = 1'b1;
      frame_start = 1'b0;
      mem_ack     = 1'b0;
      mem_rvalid  = 1'b0;
      step();
      check("final_busy", 32'(busy), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/vqueue_fill.md
Name: vqueue_fill

Overview:
- Write-side engine for the video queue: fetches framebuffer words from memory in fixed-length read bursts and pushes them into the queue's write port.
- Refills whenever the queue reports AlmostEmpty (fewer than 32 words).
- Walks the framebuffer linearly and wraps to the base address at end of frame; re-syncs to the base on a frame-start pulse.
- Sits in the memory/CPU clock domain, which is the queue's WrClock.

Parameters:
- addr_width, 24, memory word-address width.
- fb_base, 24'h0, framebuffer base word address.
- fb_words, 24576, words per frame (1024x768 at 1 bpp / 32); must be a nonzero multiple of burst_len.
- burst_len, 8, words per memory read burst; power of two, 2..32.

Ports:
- clk, input, 1, single clock; drives the queue's WrClock.
- reset, input, 1, synchronous, active-high.
- enable, input, 1, fetching allowed; sampled only in IDLE.
- frame_start, input, 1, one-cycle pulse; restart at fb_base.
- q_almost_empty, input, 1, queue AlmostEmpty (same clock domain).
- q_wren, output, 1, queue WrEn.
- q_data, output, 32, queue Data.
- mem_req, output, 1, burst read request.
- mem_addr, output, addr_width, burst start word address.
- mem_ack, input, 1, request accepted (one cycle).
- mem_rvalid, input, 1, read data beat valid.
- mem_rdata, input, 32, read data.
- busy, output, 1, burst in progress (state != IDLE).

Behaviour:
- Reset (synchronous, active-high; one clk with reset=1 suffices):
  - Outputs: mem_req=0, q_wren=0, q_data=0, busy=0.
  - State: state=IDLE, fetch address=fb_base, word_cnt=0, beat_cnt=0, restart_pend=0.
  - Reset mid-burst abandons the burst. Late mem_rvalid beats arriving afterwards are ignored.
- State machine IDLE -> REQ -> DATA -> IDLE:
  - IDLE, restart pending: clear restart_pend, set fetch address=fb_base, word_cnt=0; stay IDLE this cycle.
  - IDLE, otherwise: go to REQ when enable=1 and q_almost_empty=1.
  - REQ: mem_req=1 and mem_addr=fetch address, both held stable until the cycle mem_ack=1. After that cycle: mem_req=0, go to DATA, beat_cnt=0.
  - DATA: each mem_rvalid=1 beat increments beat_cnt. On beat burst_len-1, return to IDLE.
- Address update at end of burst:
  - Fetch address += burst_len; word_cnt += burst_len.
  - If word_cnt reaches fb_words: fetch address=fb_base and word_cnt=0 (frame wrap).
  - All arithmetic is modulo 2^addr_width.
- Queue write path, one-cycle registered latency:
  - A mem_rvalid beat accepted in DATA at cycle n gives q_wren=1, q_data=mem_rdata at cycle n+1.
  - q_wren=0 in every other cycle.
  - mem_rvalid outside DATA is ignored (no q_wren).
- frame_start:
  - Sets restart_pend in any state.
  - An in-flight REQ/DATA burst completes normally and its data is still written.
  - The restart is applied on the next IDLE cycle, before any new request.
  - frame_start coincident with reset: reset wins, and the pulse is dropped.
- Throughput and overfill bounds:
  - At most one outstanding burst.
  - q_almost_empty is re-evaluated only in IDLE, so the queue holds at most 31 + burst_len words more than the consumer drained; no Full check is needed for depth >= 64.
  - Back-to-back bursts: IDLE costs exactly one cycle between bursts.
- enable=0: takes effect only in IDLE; a burst already started always completes.

Decomposition:
- Shared package (video pkg): state encoding constants, the AlmostEmpty threshold of 32, default framebuffer geometry (fb_words for 1024x768 at 1 bpp), and default burst_len.
- No sub-module: a single flat module with one FSM, an address/word counter, and a beat counter. Instantiated alongside the queue in the video top level.

Test Plan:
- Basic refill:
  - Stimulus: reset, then enable=1, q_almost_empty=1, fb_base=0x100, mem_ack 2 cycles after mem_req, 8 rvalid beats with data 0..7.
  - Response: mem_addr=0x100; q_wren pulses 8 times, each one cycle after its rvalid, carrying 0..7. Next mem_addr=0x108.
- Handshake hold:
  - Stimulus: mem_ack delayed 10 cycles.
  - Response: mem_req and mem_addr stable for all 10 cycles; mem_req=0 the cycle after ack.
- Throttle:
  - Stimulus: q_almost_empty drops to 0 mid-burst.
  - Response: the burst completes with all 8 writes; no new mem_req while q_almost_empty=0; a new request starts 1 cycle after it returns to 1 in IDLE.
- Frame wrap:
  - Stimulus: fb_words=16, burst_len=8, fb_base=0.
  - Response: request addresses are 0, 8, 0, 8 …
- Frame restart mid-burst:
  - Stimulus: frame_start pulse during DATA at fetch address 0x40.
  - Response: the current burst finishes with 8 writes; the next mem_addr is fb_base.
- Reset mid-burst and stray beats:
  - Stimulus: reset after 3 beats; 5 further rvalid beats arrive after reset.
  - Response: no q_wren after reset; all outputs 0; the next mem_addr is fb_base.
